timer_control_fsm: RTL and testbench

Front-panel controller that sits directly upstream of the minutes/seconds counter in the MonitorVGA design. It debounces the three board buttons and sequences the timer through set, run, pause and alarm modes. It drives the counter's `enable`, `forward`, `incrementSeconds` and `incrementMinutes` inputs, and consumes its `finish` output. It also produces `alarm` and `blank` for the VGA digit renderer.

---
 rtl/timer_control_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_timer_control_fsm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_control_fsm.sv
// Front-panel sequencer: debounces start/mode/up, drives the min/sec counter, raises alarm/blink.
// Optional macro ALARM_TIMEOUT_EN: ALARM returns to IDLE on its own after ALARM_CYCLES cycles.

module timer_control_fsm #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_HALF      = 25_000_000,
  parameter int ALARM_CYCLES    = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnStart,
  input  logic       btnMode,
  input  logic       btnUp,
  input  logic       finish,
  output logic       enable,
  output logic       forward,
  output logic       incrementSeconds,
  output logic       incrementMinutes,
  output logic       alarm,
  output logic       blank,
  output logic [2:0] mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET_MIN = 3'd1,
    S_SET_SEC = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSE   = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

  logic [2:0] w_btn_raw;
  logic [2:0] w_press;
  logic       w_up_level;

  assign w_btn_raw = {btnUp, btnMode, btnStart};

  // Bit 0 = start, 1 = mode, 2 = up.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic            r_sync1;
      logic            r_sync2;
      logic            r_level;
      logic            r_level_d;
      logic            r_press;
      logic [DB_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_sync1   <= 1'b0;
          r_sync2   <= 1'b0;
          r_level   <= 1'b0;
          r_level_d <= 1'b0;
          r_press   <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_sync1   <= w_btn_raw[gi];
          r_sync2   <= r_sync1;
          if (r_sync2 != r_level) begin
            if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
              r_level <= r_sync2;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + DB_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
          r_level_d <= r_level;
          r_press   <= r_level & ~r_level_d;
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  assign w_up_level = g_btn[2].r_level;

  logic r_fin_sync1;
  logic r_fin_sync2;
  logic r_fin_d;
  logic r_fin_rise;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fin_sync1 <= 1'b0;
      r_fin_sync2 <= 1'b0;
      r_fin_d     <= 1'b0;
      r_fin_rise  <= 1'b0;
    end else begin
      r_fin_sync1 <= finish;
      r_fin_sync2 <= r_fin_sync1;
      r_fin_d     <= r_fin_sync2;
      r_fin_rise  <= r_fin_sync2 & ~r_fin_d;
    end
  end

  state_t          r_state;
  state_t          w_state_next;
  logic            w_timeout;
  logic            r_enable, w_enable_next;
  logic            r_forward, w_forward_next;
  logic            r_inc_sec, w_inc_sec_next;
  logic            r_inc_min, w_inc_min_next;
  logic            r_alarm, w_alarm_next;
  logic            r_blank, w_blank_next;
  logic [BL_W-1:0] r_blink_cnt, w_blink_cnt_next;

`ifdef ALARM_TIMEOUT_EN
  localparam int AL_W = $clog2(ALARM_CYCLES + 1);
  logic [AL_W-1:0] r_alarm_cnt;

  // Restarts from zero on every ALARM entry since it idles at zero elsewhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alarm_cnt <= '0;
    end else if (r_state == S_ALARM) begin
      r_alarm_cnt <= r_alarm_cnt + AL_W'(1);
    end else begin
      r_alarm_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_ALARM) && (r_alarm_cnt == AL_W'(ALARM_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
  if (ALARM_CYCLES < 1) begin : g_alarm_cycles_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_enable    <= 1'b0;
      r_forward   <= 1'b1;
      r_inc_sec   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_alarm     <= 1'b0;
      r_blank     <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_enable    <= w_enable_next;
      r_forward   <= w_forward_next;
      r_inc_sec   <= w_inc_sec_next;
      r_inc_min   <= w_inc_min_next;
      r_alarm     <= w_alarm_next;
      r_blank     <= w_blank_next;
      r_blink_cnt <= w_blink_cnt_next;
    end
  end

  // Priorities: start over mode over up; in RUN the finish edge wins over start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_press[0])      w_state_next = S_RUN;
        else if (w_press[1]) w_state_next = S_SET_MIN;
      end
      S_SET_MIN: begin
        if (w_press[0])      w_state_next = S_RUN;
        else if (w_press[1]) w_state_next = S_SET_SEC;
      end
      S_SET_SEC: begin
        if (w_press[0])      w_state_next = S_RUN;
        else if (w_press[1]) w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (r_fin_rise)      w_state_next = S_ALARM;
        else if (w_press[0]) w_state_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_press[0])      w_state_next = S_RUN;
        else if (w_press[1]) w_state_next = S_IDLE;
      end
      S_ALARM: begin
        if ((|w_press) || w_timeout) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_enable_next    = (w_state_next == S_RUN);
    w_alarm_next     = (w_state_next == S_ALARM);
    w_inc_min_next   = (w_state_next == S_SET_MIN) && w_up_level;
    w_inc_sec_next   = (w_state_next == S_SET_SEC) && w_up_level;
    w_forward_next   = r_forward;
    if ((r_state == S_IDLE) && !w_press[0] && !w_press[1] && w_press[2]) begin
      w_forward_next = ~r_forward;
    end
    w_blink_cnt_next = '0;
    w_blank_next     = 1'b0;
    if ((r_state == S_ALARM) && (w_state_next == S_ALARM)) begin
      if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
        w_blink_cnt_next = '0;
        w_blank_next     = ~r_blank;
      end else begin
        w_blink_cnt_next = r_blink_cnt + BL_W'(1);
        w_blank_next     = r_blank;
      end
    end
  end

  assign enable           = r_enable;
  assign forward          = r_forward;
  assign incrementSeconds = r_inc_sec;
  assign incrementMinutes = r_inc_min;
  assign alarm            = r_alarm;
  assign blank            = r_blank;
  assign mode             = r_state;

endmodule

// File: tb/tb_timer_control_fsm.sv
// Self-checking bench for timer_control_fsm: directed scenarios plus random buttons/finish/reset,
// every cycle compared against a sample-window reference model.

module tb_timer_control_fsm;

  localparam int DB = 4;
  localparam int BH = 3;
  localparam int AC = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btnStart = 1'b0;
  logic       btnMode = 1'b0;
  logic       btnUp = 1'b0;
  logic       finish = 1'b0;
  logic       enable, forward, incrementSeconds, incrementMinutes, alarm, blank;
  logic [2:0] mode;

  always #5 clk = ~clk;

  timer_control_fsm #(
    .DEBOUNCE_CYCLES(DB),
    .BLINK_HALF(BH),
    .ALARM_CYCLES(AC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btnStart(btnStart),
    .btnMode(btnMode),
    .btnUp(btnUp),
    .finish(finish),
    .enable(enable),
    .forward(forward),
    .incrementSeconds(incrementSeconds),
    .incrementMinutes(incrementMinutes),
    .alarm(alarm),
    .blank(blank),
    .mode(mode)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw sample histories; a level flips once the last DB synchronised
  // samples all disagree with it. Press acts on the FSM three edges after the level rises.
  bit [31:0] m_hist [3];
  bit [3:0]  m_lvl  [3];
  bit [31:0] m_fhist;
  int        m_state, m_cyc, m_entry;
  bit        m_fwd = 1'b1, m_inc_min, m_inc_sec, m_blank;

  task automatic model_update();
    bit [2:0] raw;
    bit [2:0] press;
    bit       fedge, old_l, diff;
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0;
        m_lvl[b]  = '0;
      end
      m_fhist = '0; m_state = 0; m_cyc = 0; m_entry = 0;
      m_fwd = 1'b1; m_inc_min = 1'b0; m_inc_sec = 1'b0; m_blank = 1'b0;
      return;
    end
    m_cyc++;
    raw = {btnUp, btnMode, btnStart};
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][30:0], raw[b]};
      old_l = m_lvl[b][0];
      diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (m_hist[b][j] == old_l) diff = 1'b0;
      m_lvl[b] = {m_lvl[b][2:0], diff ? ~old_l : old_l};
      press[b] = m_lvl[b][2] & ~m_lvl[b][3];
    end
    m_fhist = {m_fhist[30:0], finish};
    fedge = m_fhist[3] & ~m_fhist[4];
    case (m_state)
      0: if (press[0]) m_state = 3; else if (press[1]) m_state = 1; else if (press[2]) m_fwd = ~m_fwd;
      1: if (press[0]) m_state = 3; else if (press[1]) m_state = 2;
      2: if (press[0]) m_state = 3; else if (press[1]) m_state = 0;
      3: begin
        if (fedge) begin
          m_state = 5;
          m_entry = m_cyc;
        end else if (press[0]) m_state = 4;
      end
      4: if (press[0]) m_state = 3; else if (press[1]) m_state = 0;
      5: begin
        if (|press) m_state = 0;
`ifdef ALARM_TIMEOUT_EN
        else if (m_cyc - m_entry == AC) m_state = 0;
`endif
      end
      default: m_state = 0;
    endcase
    m_inc_min = (m_state == 1) && m_lvl[2][1];
    m_inc_sec = (m_state == 2) && m_lvl[2][1];
    m_blank   = (m_state == 5) && ((((m_cyc - m_entry) / BH) % 2) == 1);
  endtask

  task automatic step();
    logic [8:0] obs, exp;
    @(posedge clk);
    model_update();
    #1;
    obs = {mode, enable, forward, incrementSeconds, incrementMinutes, alarm, blank};
    exp = {3'(m_state), m_state == 3, m_fwd, m_inc_sec, m_inc_min, m_state == 5, m_blank};
    check_eq("model_outputs", 32'(obs), 32'(exp));
  endtask

  task automatic set_btn(input int which, input bit v);
    case (which)
      0:       btnStart = v;
      1:       btnMode  = v;
      default: btnUp    = v;
    endcase
  endtask

  task automatic hold_btn(input int which, input int n);
    set_btn(which, 1'b1);
    repeat (n) step();
    set_btn(which, 1'b0);
    repeat (12) step();
  endtask

  int  hc [3];
  bit  lv;

  initial begin
    repeat (3) step();
    check_eq("rst_mode", 32'(mode), 0);
    check_eq("rst_enable", 32'(enable), 0);
    check_eq("rst_forward", 32'(forward), 1);
    check_eq("rst_inc", 32'({incrementSeconds, incrementMinutes}), 0);
    check_eq("rst_alarm_blank", 32'({alarm, blank}), 0);
    $display("txn reset: mode=%0d forward=%0b", mode, forward);
    reset = 1'b1;
    repeat (2) step();

    btnStart = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 6) btnStart = 1'b0;
      step();
      if (j == 6) check_eq("start_not_early", 32'(mode), 0);
      if (j == 7) begin
        check_eq("start_mode_run", 32'(mode), 3);
        check_eq("start_enable", 32'(enable), 1);
      end
    end
    $display("txn start press: mode=%0d enable=%0b", mode, enable);
    repeat (12) step();

    hold_btn(0, 6);
    check_eq("run_to_pause", 32'(mode), 4);
    hold_btn(1, 6);
    check_eq("pause_to_idle", 32'(mode), 0);

    for (int j = 0; j < 8; j++) begin
      btnMode = ((j % 4) < 2);
      step();
    end
    btnMode = 1'b0;
    repeat (12) step();
    check_eq("bounce_ignored", 32'(mode), 0);
    hold_btn(1, 6);
    check_eq("mode_to_setmin", 32'(mode), 1);
    $display("txn bounce+mode: mode=%0d", mode);

    btnUp = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j == 10) btnUp = 1'b0;
      step();
      if (j == 5)  check_eq("incmin_before", 32'(incrementMinutes), 0);
      if (j == 6)  check_eq("incmin_rise", 32'(incrementMinutes), 1);
      if (j == 15) check_eq("incmin_last", 32'(incrementMinutes), 1);
      if (j == 16) check_eq("incmin_fall", 32'(incrementMinutes), 0);
      if (j == 6 || j == 15) check_eq("incsec_zero", 32'(incrementSeconds), 0);
    end
    $display("txn up hold in SET_MIN: mode=%0d", mode);

    hold_btn(0, 6);
    check_eq("setmin_to_run", 32'(mode), 3);
    finish = 1'b1;
    for (int j = 0; j < 104; j++) begin
      step();
      if (j == 2) check_eq("finish_not_early", 32'(mode), 3);
      if (j == 3) begin
        check_eq("finish_alarm_mode", 32'(mode), 5);
        check_eq("finish_alarm", 32'(alarm), 1);
      end
      if (j == 5) check_eq("blank_low", 32'(blank), 0);
      if (j == 6) check_eq("blank_high", 32'(blank), 1);
      if (j == 9) check_eq("blank_low_again", 32'(blank), 0);
`ifdef ALARM_TIMEOUT_EN
      if (j == 22) check_eq("timeout_not_early", 32'(mode), 5);
      if (j == 23) check_eq("timeout_idle", 32'(mode), 0);
`else
      if (j == 103) check_eq("alarm_held_100", 32'(mode), 5);
`endif
    end
    finish = 1'b0;
    repeat (6) step();
`ifndef ALARM_TIMEOUT_EN
    hold_btn(2, 6);
`endif
    check_eq("alarm_exit", 32'(mode), 0);
    $display("txn finish/alarm: mode=%0d", mode);

    hold_btn(0, 6);
    btnStart = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j == 4) finish = 1'b1;
      if (j == 6) btnStart = 1'b0;
      step();
      if (j == 6) check_eq("simul_before", 32'(mode), 3);
      if (j == 7) check_eq("finish_beats_start", 32'(mode), 5);
    end
    finish = 1'b0;
    hold_btn(1, 6);
    check_eq("alarm_mode_exit", 32'(mode), 0);
    $display("txn start+finish: mode=%0d", mode);

    hold_btn(2, 6);
    check_eq("up_toggles_fwd", 32'(forward), 0);
    hold_btn(0, 6);
    hold_btn(0, 6);
    check_eq("pause_fwd0", 32'({mode, forward}), 32'({3'd4, 1'b0}));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("midrst_mode", 32'(mode), 0);
    check_eq("midrst_forward", 32'(forward), 1);
    check_eq("midrst_enable", 32'(enable), 0);
    $display("txn mid reset: mode=%0d forward=%0b", mode, forward);

    reset = 1'b0;
    btnStart = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    for (int j = 0; j < 13; j++) begin
      step();
      if (j == 6) check_eq("held_rst_early", 32'(mode), 0);
      if (j == 7) check_eq("held_rst_press", 32'(mode), 3);
    end
    btnStart = 1'b0;
    repeat (12) step();
    check_eq("held_rst_single", 32'(mode), 3);
    $display("txn held through reset: mode=%0d", mode);

    for (int b = 0; b < 3; b++) hc[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hc[b] == 0) begin
          lv = 1'($urandom_range(0, 1));
          hc[b] = int'($urandom_range(1, 8));
          set_btn(b, lv);
        end
        hc[b]--;
      end
      if ($urandom_range(0, 39) == 0) finish = ~finish;
      reset = ($urandom_range(0, 799) != 0);
      step();
      if (c % 500 == 499) $display("txn random block %0d: mode=%0d checks=%0d", c / 500, mode, n_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
